radix5_pair_issuer: RTL
=======================

RADIX5_PAIR_ISSUER -- requirements
Module: radix5_pair_issuer

Interface
REQ-001 Parameter DATA_W, default 32, is the width of each real or imaginary word (IEEE-754 single, carried as opaque bits).
REQ-002 Parameter FRAME_LEN, default 5, gives the samples per radix-5 frame and is fixed at 5.
REQ-003 Port clk, input, 1, is the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1, is a synchronous, active-high reset.
REQ-005 in_valid input 1, in_ready output 1: upstream sample handshake; a transfer occurs when both are high.
REQ-006 in_re, in_img, input, DATA_W each: the complex input sample.
REQ-007 in_last, input, 1: marks the last sample of a frame (index 4).
REQ-008 a_re, a_img, b_re, b_img, output, DATA_W each: operand pair for the downstream half-FFT butterfly.
REQ-009 out_valid output 1, out_ready input 1: downstream pair handshake; a transfer occurs when both are high.
REQ-010 out_pair, output, 2: pair index p (0..3) of the current output.
REQ-011 out_last, output, 1: high together with p==3.
REQ-012 frame_err, output, 1: one-cycle pulse on a framing violation.

Function
REQ-013 The block SHALL hold two 5-entry banks (ping-pong), with per-bank full flags, a write-bank pointer, a read-bank pointer, a write index (0..4) and a pair counter (0..3).
REQ-014 in_ready SHALL equal NOT full[wr_bank], driven combinationally from registers only.
REQ-015 An accepted sample SHALL be written to bank[wr_bank][wr_idx]; wr_idx SHALL then increment.
REQ-016 On an accepted sample at wr_idx==4 with in_last==1, the block SHALL set full[wr_bank], toggle wr_bank and wrap wr_idx to 0.
REQ-017 On an accepted sample with in_last==1 at wr_idx!=4, or in_last==0 at wr_idx==4, the block SHALL pulse frame_err, discard the partial frame, reset wr_idx to 0 and leave wr_bank unchanged.
REQ-018 out_valid SHALL equal full[rd_bank].
REQ-019 For pair p, outputs SHALL be a = bank[rd_bank][0] and b = bank[rd_bank][p+1], with out_pair = p.
REQ-020 Output data SHALL hold stable while out_valid is high and out_ready is low.
REQ-021 On a pair transfer with p<3, p SHALL increment.
REQ-022 On a pair transfer with p==3, the block SHALL clear full[rd_bank], toggle rd_bank and set p to 0.
REQ-023 Latency: out_valid SHALL rise on the cycle after the 5th sample of a frame is accepted, if the read side is idle.
REQ-024 Sustained throughput SHALL be one frame per 5 cycles in and 4 cycles out, with no bubble when both banks alternate.
REQ-025 A fill of one bank and a drain of the other bank in the same cycle SHALL both take effect.
REQ-026 When both banks are full, in_ready SHALL be 0 until the pair p==3 transfer; in_ready SHALL return to 1 on the following cycle.

Reset
REQ-027 On rst, the block SHALL clear both full flags, wr_bank, rd_bank, wr_idx, p and frame_err, giving out_valid=0, out_last=0, out_pair=0 and in_ready=1.
REQ-028 Bank contents are not reset; a_*/b_* are don't-care while out_valid==0.
REQ-029 rst asserted mid-frame or mid-drain SHALL discard all buffered data, and no pair SHALL be issued afterwards for that data.

Structure
REQ-030 A shared package radix5_pkg SHALL hold DATA_W, FRAME_LEN=5, NUM_PAIRS=4 and the pair-index width.
REQ-031 One sub-module, r5_frame_bank, SHALL implement a single 5-entry complex register bank with a write port and two read ports (entry 0 and entry p+1), instantiated twice.

Verification
REQ-032 Reset, then a frame of re = 1.0..5.0 (0x3F800000..0x40A00000) with img = 0 and in_last on the 5th sample, out_ready=1 -> four pairs with a_re=0x3F800000, b_re=0x40000000, 0x40400000, 0x40800000, 0x40A00000, and out_last on p=3.
REQ-033 Three back-to-back frames with out_ready held 0 -> in_ready drops after the 10th accept; releasing out_ready yields 12 ordered pairs and no lost or duplicated sample.
REQ-034 in_last on the 3rd sample -> frame_err pulses for 1 cycle, no out_valid; the next 5-sample frame issues normally.
REQ-035 Random in_valid/out_ready toggling for 100 frames -> a scoreboard matches every pair and out_data stays stable under stall.
REQ-036 rst asserted while p==2 with the second bank full -> next cycle out_valid=0 and in_ready=1; a new frame issues starting from p=0.

Source files
------------

// File: rtl/radix5_pkg.sv
// Shared constants and index types for the radix-5 pair issuer.
// Sample words are carried as opaque bits; nothing here does arithmetic on them.
package radix5_pkg;
  localparam int DATA_W    = 32;
  localparam int FRAME_LEN = 5;
  localparam int NUM_PAIRS = FRAME_LEN - 1;
  localparam int PAIR_W    = $clog2(NUM_PAIRS);
  localparam int IDX_W     = $clog2(FRAME_LEN);

  typedef logic [PAIR_W-1:0] pair_t;
  typedef logic [IDX_W-1:0]  idx_t;
endpackage

// File: rtl/r5_frame_bank.sv
// One 5-entry complex sample bank: single write port, a fixed read of entry 0
// and a selectable read of entry p+1 for the butterfly operand pair.
module r5_frame_bank
  import radix5_pkg::*;
#(
  parameter int DATA_W    = radix5_pkg::DATA_W,
  parameter int FRAME_LEN = radix5_pkg::FRAME_LEN
) (
  input  logic              clk,
  input  logic              we,
  input  idx_t              widx,
  input  logic [DATA_W-1:0] wr_re,
  input  logic [DATA_W-1:0] wr_img,
  input  pair_t             rsel,
  output logic [DATA_W-1:0] e0_re,
  output logic [DATA_W-1:0] e0_img,
  output logic [DATA_W-1:0] ep_re,
  output logic [DATA_W-1:0] ep_img
);
  logic [DATA_W-1:0] re_q  [FRAME_LEN];
  logic [DATA_W-1:0] img_q [FRAME_LEN];
  idx_t              pidx;

  // Storage is data only: no reset, contents are qualified by the owner's full flag.
  always_ff @(posedge clk) begin
    if (we) begin
      re_q[widx]  <= wr_re;
      img_q[widx] <= wr_img;
    end
  end

  assign pidx   = idx_t'(rsel) + idx_t'(1);
  assign e0_re  = re_q[0];
  assign e0_img = img_q[0];
  assign ep_re  = re_q[pidx];
  assign ep_img = img_q[pidx];
endmodule

// File: rtl/radix5_pair_issuer.sv
// Ping-pong frame buffer that collects 5-sample complex frames and issues them
// as four (x0, x[p+1]) operand pairs for a half-FFT radix-5 butterfly.
module radix5_pair_issuer
  import radix5_pkg::*;
#(
  parameter int DATA_W    = radix5_pkg::DATA_W,
  parameter int FRAME_LEN = radix5_pkg::FRAME_LEN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_re,
  input  logic [DATA_W-1:0] in_img,
  input  logic              in_last,
  output logic [DATA_W-1:0] a_re,
  output logic [DATA_W-1:0] a_img,
  output logic [DATA_W-1:0] b_re,
  output logic [DATA_W-1:0] b_img,
  output logic              out_valid,
  input  logic              out_ready,
  output pair_t             out_pair,
  output logic              out_last,
  output logic              frame_err
);
  localparam idx_t  LAST_IDX  = idx_t'(FRAME_LEN - 1);
  localparam pair_t LAST_PAIR = pair_t'(NUM_PAIRS - 1);

  logic [1:0] full, full_nxt;
  logic       wr_bank, rd_bank;
  idx_t       wr_idx;
  pair_t      pair;
  logic       frame_err_q;

  logic       accept, last_slot, frame_done, frame_bad;
  logic       fire, drain_done;

  logic [DATA_W-1:0] e0_re  [2];
  logic [DATA_W-1:0] e0_img [2];
  logic [DATA_W-1:0] ep_re  [2];
  logic [DATA_W-1:0] ep_img [2];

  assign in_ready   = ~full[wr_bank];
  assign accept     = in_valid & in_ready;
  assign last_slot  = (wr_idx == LAST_IDX);
  assign frame_done = accept & last_slot & in_last;
  assign frame_bad  = accept & (in_last ^ last_slot);

  assign out_valid  = full[rd_bank];
  assign fire       = out_valid & out_ready;
  assign drain_done = fire & (pair == LAST_PAIR);

  for (genvar g = 0; g < 2; g++) begin : g_bank
    r5_frame_bank #(
      .DATA_W    (DATA_W),
      .FRAME_LEN (FRAME_LEN)
    ) u_bank (
      .clk    (clk),
      .we     (accept && (wr_bank == 1'(g))),
      .widx   (wr_idx),
      .wr_re  (in_re),
      .wr_img (in_img),
      .rsel   (pair),
      .e0_re  (e0_re[g]),
      .e0_img (e0_img[g]),
      .ep_re  (ep_re[g]),
      .ep_img (ep_img[g])
    );
  end

  // Fill and drain always target different banks, so both updates can land together.
  always_comb begin
    full_nxt = full;
    if (frame_done) full_nxt[wr_bank] = 1'b1;
    if (drain_done) full_nxt[rd_bank] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full        <= '0;
      wr_bank     <= 1'b0;
      rd_bank     <= 1'b0;
      wr_idx      <= '0;
      pair        <= '0;
      frame_err_q <= 1'b0;
    end else begin
      full        <= full_nxt;
      frame_err_q <= frame_bad;
      if (accept) begin
        if (frame_bad) begin
          wr_idx <= '0;
        end else if (last_slot) begin
          wr_idx  <= '0;
          wr_bank <= ~wr_bank;
        end else begin
          wr_idx <= wr_idx + idx_t'(1);
        end
      end
      if (fire) begin
        if (drain_done) begin
          pair    <= '0;
          rd_bank <= ~rd_bank;
        end else begin
          pair <= pair + pair_t'(1);
        end
      end
    end
  end

  // The read bank cannot be written while it is full, so the operands hold under stall.
  assign a_re      = e0_re[rd_bank];
  assign a_img     = e0_img[rd_bank];
  assign b_re      = ep_re[rd_bank];
  assign b_img     = ep_img[rd_bank];
  assign out_pair  = pair;
  assign out_last  = out_valid & (pair == LAST_PAIR);
  assign frame_err = frame_err_q;
endmodule
